// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: requester-side bundle for the data memory responder.
// Word port is zero-latency; block port is a fixed-latency 32-byte transfer.
interface data_mem_responder_if;
  logic [31:0]  data_address_2DM;
  logic         MemRead_2DM;
  logic         MemWrite_2DM;
  logic [31:0]  data_write_2DM;
  logic [1:0]   data_write_size_2DM;
  logic [31:0]  data_read_fDM;
  logic         dBlkRead;
  logic         dBlkWrite;
  logic [255:0] block_write_2DM;
  logic [255:0] block_read_fDM;
  logic         block_read_fDM_valid;
  logic         block_write_fDM_valid;

  modport master (
    output data_address_2DM, MemRead_2DM, MemWrite_2DM,
    output data_write_2DM, data_write_size_2DM,
    output dBlkRead, dBlkWrite, block_write_2DM,
    input  data_read_fDM, block_read_fDM,
    input  block_read_fDM_valid, block_write_fDM_valid
  );

  modport slave (
    input  data_address_2DM, MemRead_2DM, MemWrite_2DM,
    input  data_write_2DM, data_write_size_2DM,
    input  dBlkRead, dBlkWrite, block_write_2DM,
    output data_read_fDM, block_read_fDM,
    output block_read_fDM_valid, block_write_fDM_valid
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: big-endian word store with a combinational word port
// and a fixed-latency 32-byte block read/write port.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int BLK_LATENCY = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  data_address_2DM,
  input  logic         MemRead_2DM,
  input  logic         MemWrite_2DM,
  input  logic [31:0]  data_write_2DM,
  input  logic [1:0]   data_write_size_2DM,
  output logic [31:0]  data_read_fDM,
  input  logic         dBlkRead,
  input  logic         dBlkWrite,
  input  logic [255:0] block_write_2DM,
  output logic [255:0] block_read_fDM,
  output logic         block_read_fDM_valid,
  output logic         block_write_fDM_valid
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(BLK_LATENCY + 1);
  localparam logic [31:0] DEPTH = 32'(DEPTH_WORDS);
  localparam logic [CW-1:0] CNT_INIT = CW'(BLK_LATENCY - 1);
  localparam logic FAST = (BLK_LATENCY == 1);

  typedef enum logic [1:0] {IDLE, RD_BUSY, WR_BUSY} state_e;

  function automatic logic [AW-1:0] blk_idx(
    logic [26:0] base,
    logic [2:0]  i
  );
    logic [31:0] w;
    w = {2'b00, base, i};
    return AW'(w % DEPTH);
  endfunction

  logic [31:0]  mem_q [DEPTH_WORDS];
  logic [AW-1:0] widx;
  logic [31:0]  wr_mask;
  logic [31:0]  wr_val;
  logic [31:0]  wr_word;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rd_vld_q, rd_vld_d;
  logic          wr_vld_q, wr_vld_d;
  logic [26:0]   base_q, base_d;
  logic [255:0]  bdata_q, bdata_d;
  logic [255:0]  rdata_q, rdata_d;
  logic          snap;
  logic [26:0]   snap_base;
  logic          blk_commit;

  assign widx = AW'({2'b00, data_address_2DM[31:2]} % DEPTH);
  assign data_read_fDM = MemRead_2DM ? mem_q[widx] : '0;

  // Byte lanes are big-endian: offset 0 lives in bits [31:24].
  always_comb begin
    wr_mask = '0;
    wr_val  = '0;
    unique case (data_write_size_2DM)
      2'd0: begin
        wr_mask = '1;
        wr_val  = data_write_2DM;
      end
      2'd1: begin
        wr_mask = 32'hff00_0000 >> {data_address_2DM[1:0], 3'b000};
        wr_val  = {4{data_write_2DM[7:0]}};
      end
      2'd2: begin
        wr_mask = data_address_2DM[1] ? 32'h0000_ffff : 32'hffff_0000;
        wr_val  = {2{data_write_2DM[15:0]}};
      end
      2'd3: begin
        wr_mask = 32'h00ff_ffff;
        wr_val  = data_write_2DM;
      end
      default: ;
    endcase
    wr_word = (mem_q[widx] & ~wr_mask) | (wr_val & wr_mask);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_vld_d  = 1'b0;
    wr_vld_d  = 1'b0;
    base_d    = base_q;
    bdata_d   = bdata_q;
    rdata_d   = rdata_q;
    snap      = 1'b0;
    snap_base = base_q;
    unique case (state_q)
      IDLE: begin
        if (dBlkWrite) begin
          state_d  = WR_BUSY;
          base_d   = data_address_2DM[31:5];
          bdata_d  = block_write_2DM;
          cnt_d    = CNT_INIT;
          wr_vld_d = FAST;
        end else if (dBlkRead) begin
          state_d   = RD_BUSY;
          base_d    = data_address_2DM[31:5];
          cnt_d     = CNT_INIT;
          rd_vld_d  = FAST;
          snap      = FAST;
          snap_base = data_address_2DM[31:5];
        end
      end
      RD_BUSY: begin
        if (rd_vld_q) begin
          state_d = IDLE;
        end else begin
          cnt_d    = cnt_q - CW'(1);
          rd_vld_d = (cnt_q == CW'(1));
          snap     = rd_vld_d;
        end
      end
      WR_BUSY: begin
        if (wr_vld_q) begin
          state_d = IDLE;
        end else begin
          cnt_d    = cnt_q - CW'(1);
          wr_vld_d = (cnt_q == CW'(1));
        end
      end
      default: state_d = IDLE;
    endcase
    // Snapshot taken at the edge entering the valid cycle.
    if (snap) begin
      for (int i = 0; i < 8; i++) begin
        rdata_d[255-32*i -: 32] = mem_q[blk_idx(snap_base, 3'(i))];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rd_vld_q <= 1'b0;
      wr_vld_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_vld_q <= rd_vld_d;
      wr_vld_q <= wr_vld_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge CLK) begin
    base_q  <= base_d;
    bdata_q <= bdata_d;
  end

  assign blk_commit = (state_q == WR_BUSY) && wr_vld_q && !RESET;

  // Block write is issued last so it wins over a same-edge word write.
  always_ff @(posedge CLK) begin
    if (MemWrite_2DM) begin
      mem_q[widx] <= wr_word;
    end
    if (blk_commit) begin
      for (int i = 0; i < 8; i++) begin
        mem_q[blk_idx(base_q, 3'(i))] <= bdata_q[255-32*i -: 32];
      end
    end
  end

  assign block_read_fDM        = rdata_q;
  assign block_read_fDM_valid  = rd_vld_q;
  assign block_write_fDM_valid = wr_vld_q;
endmodule
